// File: rtl/rf_ram_sched_if.sv
// Bundle of the control-unit request channels, engine start/done lines and status
// between rf_ram_sched (slave side) and its surroundings (master side).
interface rf_ram_sched_if #(
   parameter int RF_ADDR_W    = 10,
   parameter int LINE_NUM_W   = 11,
   parameter int SDRAM_ADDR_W = 32
);
   logic                    mv_req_valid;
   logic                    mv_req_ready;
   logic [RF_ADDR_W-1:0]    mv_req_src;
   logic [RF_ADDR_W-1:0]    mv_req_dst;
   logic [LINE_NUM_W-1:0]   mv_req_lines;

   logic                    ls_req_valid;
   logic                    ls_req_ready;
   logic                    ls_req_store;
   logic [RF_ADDR_W-1:0]    ls_req_rf_addr;
   logic [SDRAM_ADDR_W-1:0] ls_req_sd_addr;
   logic [LINE_NUM_W-1:0]   ls_req_lines;

   logic                    mv_start;
   logic [RF_ADDR_W-1:0]    mv_src;
   logic [RF_ADDR_W-1:0]    mv_dst;
   logic [LINE_NUM_W-1:0]   mv_lines;
   logic                    mv_done;

   logic                    ls_start;
   logic                    ls_store;
   logic [RF_ADDR_W-1:0]    ls_rf_addr;
   logic [SDRAM_ADDR_W-1:0] ls_sd_addr;
   logic [LINE_NUM_W-1:0]   ls_lines;
   logic                    ls_done;

   logic                    ram_sel;
   logic                    busy;
   logic                    cmd_done;
   logic                    cmd_done_is_ls;
   logic                    err_timeout;
   logic                    err_clr;

   modport slave (
      input  mv_req_valid, mv_req_src, mv_req_dst, mv_req_lines,
      input  ls_req_valid, ls_req_store, ls_req_rf_addr, ls_req_sd_addr, ls_req_lines,
      input  mv_done, ls_done, err_clr,
      output mv_req_ready, ls_req_ready,
      output mv_start, mv_src, mv_dst, mv_lines,
      output ls_start, ls_store, ls_rf_addr, ls_sd_addr, ls_lines,
      output ram_sel, busy, cmd_done, cmd_done_is_ls, err_timeout
   );

   modport master (
      output mv_req_valid, mv_req_src, mv_req_dst, mv_req_lines,
      output ls_req_valid, ls_req_store, ls_req_rf_addr, ls_req_sd_addr, ls_req_lines,
      output mv_done, ls_done, err_clr,
      input  mv_req_ready, ls_req_ready,
      input  mv_start, mv_src, mv_dst, mv_lines,
      input  ls_start, ls_store, ls_rf_addr, ls_sd_addr, ls_lines,
      input  ram_sel, busy, cmd_done, cmd_done_is_ls, err_timeout
   );
endinterface

// File: rtl/rf_ram_sched.sv
// rf_ram_sched: round-robin scheduler sharing the RF RAM port between rf_move and rf_ldst.
// state  | meaning
// IDLE   | arbitrate requests, accept one
// SETTLE | ram_sel just switched, let bram_mux settle
// START  | granted engine's start pulse is high, watchdog loaded
// WAIT   | wait for granted engine's done or watchdog terminal count
module rf_ram_sched #(
   parameter int RF_ADDR_W    = 10,
   parameter int LINE_NUM_W   = 11,
   parameter int SDRAM_ADDR_W = 32,
   parameter int TIMEOUT_W    = 16,
   parameter int TIMEOUT_CYC  = 40000
) (
   input  logic          clk,
   input  logic          rst,
   rf_ram_sched_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_START  = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WDOG_LOAD = TIMEOUT_W'(TIMEOUT_CYC - 1);

   state_t                  r_state;
   logic                    r_last_ls;
   logic                    r_ram_sel;
   logic                    r_mv_start;
   logic                    r_ls_start;
   logic                    r_cmd_done;
   logic                    r_cmd_done_is_ls;
   logic                    r_err;
   logic [TIMEOUT_W-1:0]    r_wdog;

   logic [RF_ADDR_W-1:0]    r_mv_src;
   logic [RF_ADDR_W-1:0]    r_mv_dst;
   logic [LINE_NUM_W-1:0]   r_mv_lines;
   logic                    r_ls_store;
   logic [RF_ADDR_W-1:0]    r_ls_rf_addr;
   logic [SDRAM_ADDR_W-1:0] r_ls_sd_addr;
   logic [LINE_NUM_W-1:0]   r_ls_lines;

   logic                    w_idle;
   logic                    w_gnt_mv;
   logic                    w_gnt_ls;
   logic                    w_cur_zero;
   logic                    w_cur_done;
   logic                    w_wdog_tc;

   // On a tie the engine that did not win last time gets the port.
   assign w_idle     = (r_state == S_IDLE);
   assign w_gnt_mv   = w_idle & bus.mv_req_valid & (~bus.ls_req_valid | r_last_ls);
   assign w_gnt_ls   = w_idle & bus.ls_req_valid & (~bus.mv_req_valid | ~r_last_ls);
   assign w_cur_zero = r_ram_sel ? (r_ls_lines == '0) : (r_mv_lines == '0);
   assign w_cur_done = r_ram_sel ? bus.ls_done : bus.mv_done;
   assign w_wdog_tc  = (r_wdog == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_last_ls        <= 1'b1;
         r_ram_sel        <= 1'b0;
         r_mv_start       <= 1'b0;
         r_ls_start       <= 1'b0;
         r_cmd_done       <= 1'b0;
         r_cmd_done_is_ls <= 1'b0;
         r_err            <= 1'b0;
         r_wdog           <= '0;
         r_mv_src         <= '0;
         r_mv_dst         <= '0;
         r_mv_lines       <= '0;
         r_ls_store       <= 1'b0;
         r_ls_rf_addr     <= '0;
         r_ls_sd_addr     <= '0;
         r_ls_lines       <= '0;
      end else begin
         r_mv_start <= 1'b0;
         r_ls_start <= 1'b0;
         r_cmd_done <= 1'b0;
         if (bus.err_clr) begin
            r_err <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_gnt_mv) begin
                  r_mv_src   <= bus.mv_req_src;
                  r_mv_dst   <= bus.mv_req_dst;
                  r_mv_lines <= bus.mv_req_lines;
                  r_ram_sel  <= 1'b0;
                  r_last_ls  <= 1'b0;
                  r_state    <= S_SETTLE;
               end else if (w_gnt_ls) begin
                  r_ls_store   <= bus.ls_req_store;
                  r_ls_rf_addr <= bus.ls_req_rf_addr;
                  r_ls_sd_addr <= bus.ls_req_sd_addr;
                  r_ls_lines   <= bus.ls_req_lines;
                  r_ram_sel    <= 1'b1;
                  r_last_ls    <= 1'b1;
                  r_state      <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               // Zero-line commands complete without ever waking the engine.
               if (w_cur_zero) begin
                  r_cmd_done       <= 1'b1;
                  r_cmd_done_is_ls <= r_ram_sel;
                  r_state          <= S_IDLE;
               end else begin
                  r_mv_start <= ~r_ram_sel;
                  r_ls_start <= r_ram_sel;
                  r_state    <= S_START;
               end
            end

            S_START: begin
               r_wdog  <= WDOG_LOAD;
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               if (w_cur_done) begin
                  r_cmd_done       <= 1'b1;
                  r_cmd_done_is_ls <= r_ram_sel;
                  r_state          <= S_IDLE;
               end else if (w_wdog_tc) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog - 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mv_req_ready   = w_gnt_mv;
   assign bus.ls_req_ready   = w_gnt_ls;
   assign bus.mv_start       = r_mv_start;
   assign bus.mv_src         = r_mv_src;
   assign bus.mv_dst         = r_mv_dst;
   assign bus.mv_lines       = r_mv_lines;
   assign bus.ls_start       = r_ls_start;
   assign bus.ls_store       = r_ls_store;
   assign bus.ls_rf_addr     = r_ls_rf_addr;
   assign bus.ls_sd_addr     = r_ls_sd_addr;
   assign bus.ls_lines       = r_ls_lines;
   assign bus.ram_sel        = r_ram_sel;
   assign bus.busy           = ~w_idle;
   assign bus.cmd_done       = r_cmd_done;
   assign bus.cmd_done_is_ls = r_cmd_done_is_ls;
   assign bus.err_timeout    = r_err;

endmodule

// File: tb/tb_rf_ram_sched.sv
// Self-checking bench for rf_ram_sched: command table, corner-case sequences and a
// randomized run against a cycle-scheduling reference model.
module tb_rf_ram_sched;

   localparam int TO  = 8;
   localparam int INF = 32'h3fff_ffff;

   typedef struct {
      bit          is_ls;
      bit          store;
      logic [9:0]  a;
      logic [9:0]  b;
      logic [31:0] sd;
      logic [10:0] lines;
      int          delay;
      int          exp_lat;
      int          exp_start;
   } vec_t;

   typedef struct {
      bit mv_v;
      bit ls_v;
      bit exp_mv_rdy;
      bit exp_ls_rdy;
   } arb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rf_ram_sched_if #(.RF_ADDR_W(10), .LINE_NUM_W(11), .SDRAM_ADDR_W(32)) bus ();

   rf_ram_sched #(
      .RF_ADDR_W(10), .LINE_NUM_W(11), .SDRAM_ADDR_W(32),
      .TIMEOUT_W(16), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit actual=expired required=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mv_req_valid = 0; bus.mv_req_src = '0; bus.mv_req_dst = '0; bus.mv_req_lines = '0;
      bus.ls_req_valid = 0; bus.ls_req_store = 0; bus.ls_req_rf_addr = '0;
      bus.ls_req_sd_addr = '0; bus.ls_req_lines = '0;
      bus.mv_done = 0; bus.ls_done = 0; bus.err_clr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      #1;
   endtask

   task automatic drive_req(input vec_t v, input bit valid);
      if (v.is_ls) begin
         bus.ls_req_valid = valid; bus.ls_req_store = v.store; bus.ls_req_rf_addr = v.a;
         bus.ls_req_sd_addr = v.sd; bus.ls_req_lines = v.lines;
      end else begin
         bus.mv_req_valid = valid; bus.mv_req_src = v.a; bus.mv_req_dst = v.b;
         bus.mv_req_lines = v.lines;
      end
   endtask

   // Issue one command; the engine answers done once, delay cycles after the start cycle.
   task automatic run_cmd(input vec_t v, input string tag);
      bit   acc = 0;
      int   k_start = -1;
      int   k_done = -1;
      logic d_is_ls = 1'bx;
      logic d_sel = 1'bx;
      drive_req(v, 1);
      #1;
      for (int w = 0; w < 20; w++) begin
         if (v.is_ls ? bus.ls_req_ready : bus.mv_req_ready) begin
            acc = 1;
            break;
         end
         tick();
      end
      chk({tag, "_accept"}, acc, 1);
      tick();
      drive_req(v, 0);
      for (int k = 1; k <= 40; k++) begin
         if (v.is_ls) bus.ls_done = (v.lines != 0) && (k == 2 + v.delay);
         else         bus.mv_done = (v.lines != 0) && (k == 2 + v.delay);
         #1;
         if ((v.is_ls ? bus.ls_start : bus.mv_start) && k_start < 0) k_start = k;
         if (bus.cmd_done) begin
            k_done = k; d_is_ls = bus.cmd_done_is_ls; d_sel = bus.ram_sel;
         end
         tick();
         if (k_done >= 0) break;
      end
      bus.mv_done = 0;
      bus.ls_done = 0;
      chk({tag, "_done_latency"}, 64'(k_done), 64'(v.exp_lat));
      chk({tag, "_start_cycle"}, 64'(k_start), 64'(v.exp_start));
      chk({tag, "_done_is_ls"}, d_is_ls, v.is_ls);
      chk({tag, "_ram_sel"}, d_sel, v.is_ls);
      if (v.is_ls) begin
         chk({tag, "_ls_fields"}, {bus.ls_store, bus.ls_rf_addr, bus.ls_sd_addr, bus.ls_lines},
             {v.store, v.a, v.sd, v.lines});
      end else begin
         chk({tag, "_mv_fields"}, {bus.mv_src, bus.mv_dst, bus.mv_lines}, {v.a, v.b, v.lines});
      end
   endtask

   vec_t tbl[6];
   arb_t arb[4];

   // reference model state
   int          m_free, m_acc, m_start_cyc, m_done_cyc;
   bit          m_ls, m_zero, m_done_ls, m_last_ls, m_sel, m_err;
   logic [9:0]  m_mv_src, m_mv_dst, m_ls_rf;
   logic [10:0] m_mv_lines, m_ls_lines;
   logic [31:0] m_ls_sd;
   bit          m_ls_store;

   initial begin
      int   gr[3];
      logic sel[3];
      int   n, g, k_done;
      bit   seen;
      logic d_is_ls;

      tbl[0] = '{0, 0, 10'd5,    10'd100,  32'h0,         11'd3,     4, 7,  2};
      tbl[1] = '{1, 1, 10'd10,   10'd0,    32'h1000_0040, 11'd0,     0, 2, -1};
      tbl[2] = '{0, 0, 10'd7,    10'd9,    32'h0,         11'd0,     0, 2, -1};
      tbl[3] = '{1, 0, 10'd3,    10'd0,    32'hdead_beef, 11'd5,     1, 4,  2};
      tbl[4] = '{1, 1, 10'd1023, 10'd0,    32'hffff_fffc, 11'h7ff,   3, 6,  2};
      tbl[5] = '{0, 0, 10'd1023, 10'd1022, 32'h0,         11'd1,     2, 5,  2};

      arb[0] = '{0, 0, 0, 0};
      arb[1] = '{1, 0, 1, 0};
      arb[2] = '{0, 1, 0, 1};
      arb[3] = '{1, 1, 1, 0};

      do_reset();

      chk("rst_busy", bus.busy, 0);
      chk("rst_ram_sel", bus.ram_sel, 0);
      chk("rst_starts", {bus.mv_start, bus.ls_start}, 0);
      chk("rst_cmd_done", {bus.cmd_done, bus.cmd_done_is_ls}, 0);
      chk("rst_err", bus.err_timeout, 0);
      chk("rst_mv_fields", {bus.mv_src, bus.mv_dst, bus.mv_lines}, 0);
      chk("rst_ls_fields", {bus.ls_store, bus.ls_rf_addr, bus.ls_sd_addr, bus.ls_lines}, 0);

      // IDLE arbitration straight out of reset (last grant = ldst).
      for (int i = 0; i < 4; i++) begin
         bus.mv_req_valid = arb[i].mv_v;
         bus.ls_req_valid = arb[i].ls_v;
         #1;
         chk($sformatf("arb%0d_mv_ready", i), bus.mv_req_ready, arb[i].exp_mv_rdy);
         chk($sformatf("arb%0d_ls_ready", i), bus.ls_req_ready, arb[i].exp_ls_rdy);
      end
      bus.mv_req_valid = 0;
      bus.ls_req_valid = 0;
      #1;

      for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

      // Strict alternation with both requesters held.
      do_reset();
      bus.mv_req_valid = 1; bus.mv_req_lines = '0;
      bus.ls_req_valid = 1; bus.ls_req_lines = '0;
      #1;
      n = 0;
      for (int k = 0; k < 30 && n < 3; k++) begin
         g = -1;
         if (bus.mv_req_ready) g = 0;
         if (bus.ls_req_ready) g = (g == 0) ? 2 : 1;
         tick();
         if (g >= 0) begin
            gr[n] = g; sel[n] = bus.ram_sel; n++;
         end
      end
      bus.mv_req_valid = 0;
      bus.ls_req_valid = 0;
      chk("alt_count", 64'(n), 3);
      chk("alt_grant0", 64'(gr[0]), 0);
      chk("alt_grant1", 64'(gr[1]), 1);
      chk("alt_grant2", 64'(gr[2]), 0);
      chk("alt_sel", {sel[0], sel[1], sel[2]}, 3'b010);
      repeat (3) tick();

      // Watchdog: ldst never answers.
      for (int pass = 0; pass < 2; pass++) begin
         bus.err_clr = (pass == 1);
         bus.ls_req_valid = 1; bus.ls_req_lines = 11'd2; bus.ls_req_rf_addr = 10'd44;
         #1;
         chk($sformatf("to%0d_ready", pass), bus.ls_req_ready, 1);
         tick();
         bus.ls_req_valid = 0;
         seen = 0;
         for (int k = 1; k <= 12; k++) begin
            #1;
            if (bus.cmd_done) seen = 1;
            if (k == 10) begin
               chk($sformatf("to%0d_err_before", pass), bus.err_timeout, pass == 1 ? 1'b0 : 1'b0);
               chk($sformatf("to%0d_busy_before", pass), bus.busy, 1);
            end
            if (k == 11) begin
               chk($sformatf("to%0d_err_set", pass), bus.err_timeout, 1);
               chk($sformatf("to%0d_busy_after", pass), bus.busy, 0);
            end
            if (k == 12 && pass == 1) chk("to1_err_cleared_by_held_clr", bus.err_timeout, 0);
            tick();
         end
         chk($sformatf("to%0d_no_cmd_done", pass), seen, 0);
         if (pass == 0) begin
            chk("to0_err_sticky", bus.err_timeout, 1);
            bus.err_clr = 1;
            tick();
            bus.err_clr = 0;
            #1;
            chk("to0_err_clr", bus.err_timeout, 0);
         end
      end
      bus.err_clr = 0;

      // Spurious mv_done in WAIT and early ls_done in START are both ignored.
      bus.ls_req_valid = 1; bus.ls_req_lines = 11'd2;
      #1;
      chk("spur_ready", bus.ls_req_ready, 1);
      tick();
      bus.ls_req_valid = 0;
      k_done = -1; d_is_ls = 1'bx;
      for (int k = 1; k <= 12; k++) begin
         bus.mv_done = (k == 4);
         bus.ls_done = (k == 2) || (k == 7);
         #1;
         if (bus.cmd_done && k_done < 0) begin
            k_done = k; d_is_ls = bus.cmd_done_is_ls;
         end
         tick();
      end
      bus.mv_done = 0;
      bus.ls_done = 0;
      chk("spur_done_cycle", 64'(k_done), 8);
      chk("spur_done_is_ls", d_is_ls, 1);

      // Async reset while an ldst is in WAIT.
      bus.ls_req_valid = 1; bus.ls_req_lines = 11'd3; bus.ls_req_sd_addr = 32'h55aa_0000;
      #1;
      tick();
      bus.ls_req_valid = 0;
      repeat (3) tick();
      chk("rstw_busy_before", bus.busy, 1);
      rst = 1;
      #1;
      chk("rstw_busy", bus.busy, 0);
      chk("rstw_ram_sel", bus.ram_sel, 0);
      chk("rstw_ls_fields", {bus.ls_sd_addr, bus.ls_lines}, 0);
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         bus.ls_done = 1;
         tick();
         if (bus.cmd_done || bus.mv_start || bus.ls_start) seen = 1;
      end
      bus.ls_done = 0;
      rst = 0;
      #1;
      chk("rstw_no_pulses", seen, 0);
      run_cmd(tbl[0], "rstw_new");

      // Randomized run against the scheduling model.
      do_reset();
      m_free = 0; m_acc = -100; m_start_cyc = -1; m_done_cyc = -1;
      m_ls = 0; m_zero = 0; m_done_ls = 0; m_last_ls = 1; m_sel = 0; m_err = 0;
      m_mv_src = '0; m_mv_dst = '0; m_mv_lines = '0;
      m_ls_store = 0; m_ls_rf = '0; m_ls_sd = '0; m_ls_lines = '0;
      for (int c = 0; c < 700; c++) begin
         bit idle, e_mvr, e_lsr, timeout, gd;
         bus.mv_req_valid   = ($urandom_range(0, 2) != 0);
         bus.ls_req_valid   = ($urandom_range(0, 2) != 0);
         bus.mv_req_src     = 10'($urandom);
         bus.mv_req_dst     = 10'($urandom);
         bus.mv_req_lines   = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
         bus.ls_req_store   = 1'($urandom);
         bus.ls_req_rf_addr = 10'($urandom);
         bus.ls_req_sd_addr = $urandom;
         bus.ls_req_lines   = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
         bus.mv_done        = ($urandom_range(0, 5) == 0);
         bus.ls_done        = ($urandom_range(0, 5) == 0);
         bus.err_clr        = ($urandom_range(0, 15) == 0);
         #1;
         idle  = (c >= m_free);
         e_mvr = idle && bus.mv_req_valid && (!bus.ls_req_valid || m_last_ls);
         e_lsr = idle && bus.ls_req_valid && (!bus.mv_req_valid || !m_last_ls);
         chk("rnd_ready", {bus.mv_req_ready, bus.ls_req_ready}, {e_mvr, e_lsr});
         chk("rnd_busy", bus.busy, !idle);
         chk("rnd_mv_start", bus.mv_start, (c == m_start_cyc) && !m_ls);
         chk("rnd_ls_start", bus.ls_start, (c == m_start_cyc) && m_ls);
         chk("rnd_cmd_done", bus.cmd_done, c == m_done_cyc);
         if (c == m_done_cyc) chk("rnd_cmd_done_is_ls", bus.cmd_done_is_ls, m_done_ls);
         chk("rnd_ram_sel", bus.ram_sel, m_sel);
         chk("rnd_err", bus.err_timeout, m_err);
         chk("rnd_mv_fields", {bus.mv_src, bus.mv_dst, bus.mv_lines},
             {m_mv_src, m_mv_dst, m_mv_lines});
         chk("rnd_ls_fields", {bus.ls_store, bus.ls_rf_addr, bus.ls_sd_addr, bus.ls_lines},
             {m_ls_store, m_ls_rf, m_ls_sd, m_ls_lines});

         timeout = 0;
         if (!idle && !m_zero && c >= m_acc + 3) begin
            gd = m_ls ? bus.ls_done : bus.mv_done;
            if (gd) begin
               m_free = c + 1; m_done_cyc = c + 1; m_done_ls = m_ls;
            end else if (c == m_acc + 2 + TO) begin
               m_free = c + 1; timeout = 1;
            end
         end
         if (timeout) m_err = 1;
         else if (bus.err_clr) m_err = 0;
         if (e_mvr || e_lsr) begin
            m_acc = c; m_ls = e_lsr; m_sel = e_lsr; m_last_ls = e_lsr;
            if (e_lsr) begin
               m_ls_store = bus.ls_req_store; m_ls_rf = bus.ls_req_rf_addr;
               m_ls_sd = bus.ls_req_sd_addr; m_ls_lines = bus.ls_req_lines;
               m_zero = (bus.ls_req_lines == 0);
            end else begin
               m_mv_src = bus.mv_req_src; m_mv_dst = bus.mv_req_dst;
               m_mv_lines = bus.mv_req_lines;
               m_zero = (bus.mv_req_lines == 0);
            end
            if (m_zero) begin
               m_free = c + 2; m_done_cyc = c + 2; m_done_ls = e_lsr; m_start_cyc = -1;
            end else begin
               m_free = INF; m_start_cyc = c + 2;
            end
         end
         tick();
      end
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
